// File: rtl/siphash_pkg.sv
// Shared definitions for the SipHash byte-stream packer: word geometry and the
// packer's state encoding.
package siphash_pkg;

  localparam int SIPHASH_WORD_W       = 64;
  localparam int SIPHASH_LANES        = 8;
  localparam int SIPHASH_LENBYTE_LANE = 7;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_INIT    = 4'd1,
    ST_COLLECT = 4'd2,
    ST_COMP    = 4'd3,
    ST_GUARD   = 4'd4,
    ST_WAIT    = 4'd5,
    ST_FIN     = 4'd6,
    ST_FGUARD  = 4'd7,
    ST_FWAIT   = 4'd8,
    ST_DONE    = 4'd9
  } siphash_state_e;

endpackage

// File: rtl/siphash_word_assembler.sv
// Combinational next-word builder: optional clear, little-endian byte-lane write
// and merge of the message-length byte into lane 7.
import siphash_pkg::*;

module siphash_word_assembler (
  input  logic [SIPHASH_WORD_W-1:0] word_i,
  input  logic                      clear_i,
  input  logic [2:0]                idx_i,
  input  logic [7:0]                byte_i,
  input  logic                      byte_we_i,
  input  logic [7:0]                len_byte_i,
  input  logic                      len_we_i,
  output logic [SIPHASH_WORD_W-1:0] word_o
);

  always_comb begin
    word_o = clear_i ? '0 : word_i;
    for (int lane = 0; lane < SIPHASH_LANES; lane++) begin
      // The data byte wins; the controller never asks for both on lane 7.
      if (byte_we_i && (idx_i == 3'(lane))) begin
        word_o[8*lane +: 8] = byte_i;
      end else if (len_we_i && (lane == SIPHASH_LENBYTE_LANE)) begin
        word_o[8*lane +: 8] = len_byte_i;
      end
    end
  end

endmodule

// File: rtl/siphash_msg_packer.sv
// Byte-stream front end for the SipHash core: packs bytes into 64-bit words,
// appends length padding and sequences initialize/compress/finalize pulses.
// Define SIPHASH_PACKER_LEN_EN to export a LEN_W-bit msg_len byte counter.
import siphash_pkg::*;

module siphash_msg_packer #(
  parameter int LEN_W = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        start_empty,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        core_ready,
  output logic        core_initalize,
  output logic        core_compress,
  output logic        core_finalize,
  output logic [63:0] core_mi,
  output logic        busy,
  output logic        done
`ifdef SIPHASH_PACKER_LEN_EN
  ,
  output logic [LEN_W-1:0] msg_len
`endif
);

  // Handshake: a byte transfers on a rising clk edge where in_valid && in_ready;
  // in_ready is registered and high only in COLLECT, so in_data/in_last must be
  // held stable by the source until that edge.

`ifdef SIPHASH_PACKER_LEN_EN
  localparam int CNT_W = LEN_W;
`else
  localparam int CNT_W = 8;
`endif

  siphash_state_e state_q, state_d;

  logic [SIPHASH_WORD_W-1:0] word_q, word_d;
  logic [2:0]                idx_q, idx_d;
  logic [CNT_W-1:0]          len_q, len_d;
  logic                      last_q, last_d;
  logic                      lenw_q, lenw_d;

  logic                      in_ready_q;
  logic                      init_q;
  logic                      comp_q;
  logic                      fin_q;
  logic [SIPHASH_WORD_W-1:0] mi_q;
  logic                      busy_q;
  logic                      done_q;

  logic                      asm_clear;
  logic                      asm_byte_we;
  logic                      asm_len_we;
  logic [7:0]                asm_len_byte;

  siphash_word_assembler u_asm (
    .word_i     (word_q),
    .clear_i    (asm_clear),
    .idx_i      (idx_q),
    .byte_i     (in_data),
    .byte_we_i  (asm_byte_we),
    .len_byte_i (asm_len_byte),
    .len_we_i   (asm_len_we),
    .word_o     (word_d)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    len_d        = len_q;
    last_d       = last_q;
    lenw_d       = lenw_q;
    asm_clear    = 1'b0;
    asm_byte_we  = 1'b0;
    asm_len_we   = 1'b0;
    asm_len_byte = len_q[7:0];

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          asm_clear = 1'b1;
          idx_d     = 3'd0;
          len_d     = '0;
          // An empty message is already its own length word (all zero).
          last_d    = start_empty;
          lenw_d    = start_empty;
          state_d   = ST_INIT;
        end
      end
      ST_INIT: begin
        state_d = last_q ? ST_COMP : ST_COLLECT;
      end
      ST_COLLECT: begin
        if (in_valid && in_ready_q) begin
          asm_byte_we = 1'b1;
          idx_d       = idx_q + 3'd1;
          len_d       = len_q + CNT_W'(1);
          if (in_last) begin
            last_d = 1'b1;
          end
          // A partial final word carries the length byte itself.
          if (in_last && (idx_q != 3'd7)) begin
            asm_len_we   = 1'b1;
            asm_len_byte = len_d[7:0];
            lenw_d       = 1'b1;
          end
          if ((idx_q == 3'd7) || in_last) begin
            state_d = ST_COMP;
          end
        end
      end
      ST_COMP: begin
        state_d = ST_GUARD;
      end
      ST_GUARD: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_ready) begin
          if (!last_q) begin
            asm_clear = 1'b1;
            idx_d     = 3'd0;
            state_d   = ST_COLLECT;
          end else if (!lenw_q) begin
            asm_clear    = 1'b1;
            asm_len_we   = 1'b1;
            asm_len_byte = len_q[7:0];
            lenw_d       = 1'b1;
            state_d      = ST_COMP;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_FGUARD;
      end
      ST_FGUARD: begin
        state_d = ST_FWAIT;
      end
      ST_FWAIT: begin
        if (core_ready) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      idx_q      <= 3'd0;
      len_q      <= '0;
      last_q     <= 1'b0;
      lenw_q     <= 1'b0;
      in_ready_q <= 1'b0;
      init_q     <= 1'b0;
      comp_q     <= 1'b0;
      fin_q      <= 1'b0;
      mi_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      last_q     <= last_d;
      lenw_q     <= lenw_d;
      // Outputs are decoded from the next state so they line up with state_q.
      in_ready_q <= (state_d == ST_COLLECT);
      init_q     <= (state_d == ST_INIT);
      comp_q     <= (state_d == ST_COMP);
      fin_q      <= (state_d == ST_FIN);
      if (state_d == ST_COMP) begin
        mi_q <= word_d;
      end
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_DONE);
    end
  end

  assign in_ready       = in_ready_q;
  assign core_initalize = init_q;
  assign core_compress  = comp_q;
  assign core_finalize  = fin_q;
  assign core_mi        = mi_q;
  assign busy           = busy_q;
  assign done           = done_q;

`ifdef SIPHASH_PACKER_LEN_EN
  assign msg_len = len_q;
`endif

endmodule
